// File: rtl/prog_clock_divider.sv
// prog_clock_divider: NUM_CH programmable clock dividers, all clocked by cin.
// Each channel counts enabled cin cycles from 0 up to its active divisor.
// At that terminal count it emits a one-cycle tick and toggles cout.
// New divisors are written to a per-channel shadow register through
// div_ld/div_sel/div_val. A shadow value becomes active only at the channel's
// terminal event or on sync_clr, so a running period is never cut short or
// stretched.
// Optional feature: define CLKDIV_CASCADE_EN to chain the channels into a
// prescaler. Channel k>0 then counts only in cycles where tick[k-1] is high.
// Without the macro every channel counts cin directly.

module prog_clock_divider #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = 60,
    parameter int SEL_W   = 2
) (
    input  logic              cin,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sync_clr,
    input  logic              div_ld,
    input  logic [SEL_W-1:0]  div_sel,
    input  logic [CNT_W-1:0]  div_val,
    output logic [NUM_CH-1:0] ld_pend,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] cout
);

    localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;     // position within the current period
        logic [CNT_W-1:0] r_active;  // terminal count in use now
        logic [CNT_W-1:0] r_shadow;  // terminal count waiting to be applied
        logic             r_pend;    // shadow holds a value not yet applied
        logic             r_tick;
        logic             r_cout;
        logic             w_event;   // this channel advances on this edge
        logic             w_term;    // this event closes the current period
        logic             w_hit;     // divisor load addressed to this channel

`ifdef CLKDIV_CASCADE_EN
        if (g == 0) begin : g_head
            assign w_event = en;
        end else begin : g_link
            // The upstream tick is registered. This channel therefore counts
            // in the cycle after each upstream terminal.
            assign w_event = en & tick[g-1];
        end
`else
        assign w_event = en;
`endif

        // Decode the terminal event and the load address for this channel.
        always_comb begin
            w_term = w_event && (r_cnt == r_active);
            w_hit  = div_ld && (int'(div_sel) == g);
        end

        // Update the counter, the divisor pair, the pending flag and the
        // registered outputs.
        // NOTE: every register here, including the divisor registers, is
        // reset. The state is a handful of flops per channel, and a known
        // divisor is required right after reset.
        always_ff @(posedge cin or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt    <= '0;
                r_active <= DEF_DIV_C;
                r_shadow <= DEF_DIV_C;
                r_pend   <= 1'b0;
                r_tick   <= 1'b0;
                r_cout   <= 1'b0;
            end else begin
                // NOTE: non-blocking assignments make every read below see
                // the pre-edge value. A terminal event therefore moves the
                // old shadow to active, even when a load in the same cycle
                // overwrites the shadow.
                if (w_hit) begin
                    r_shadow <= div_val;
                end

                if (sync_clr) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b0;
                    r_cout <= 1'b0;
                    if (r_pend) begin
                        r_active <= r_shadow;
                    end
                end else begin
                    r_tick <= w_term;
                    if (w_event) begin
                        r_cnt <= w_term ? '0 : r_cnt + 1'b1;
                    end
                    if (w_term) begin
                        r_cout <= ~r_cout;
                        if (r_pend) begin
                            r_active <= r_shadow;
                        end
                    end
                end

                // A load arriving in this cycle keeps the flag set for the
                // next application point.
                if (w_hit) begin
                    r_pend <= 1'b1;
                end else if (sync_clr || w_term) begin
                    r_pend <= 1'b0;
                end
            end
        end

        assign ld_pend[g] = r_pend;
        assign tick[g]    = r_tick;
        assign cout[g]    = r_cout;
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Self-checking bench for prog_clock_divider (NUM_CH=4, DEF_DIV=60, SEL_W=3).
// The bench builds each expected output when it drives the stimulus and
// queues it in a scoreboard. It pops and compares the entry 1 ns after the
// next cin rising edge.
module tb_prog_clock_divider;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 16;
    localparam int DEF_DIV = 60;
    localparam int SEL_W   = 3;
    localparam int DEF_P   = DEF_DIV + 1;

    logic              cin = 1'b0;
    logic              rst_n = 1'b1;
    logic              en = 1'b0;
    logic              sync_clr = 1'b0;
    logic              div_ld = 1'b0;
    logic [SEL_W-1:0]  div_sel = '0;
    logic [CNT_W-1:0]  div_val = '0;
    logic [NUM_CH-1:0] ld_pend;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] cout;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [NUM_CH-1:0] tick;
        logic [NUM_CH-1:0] cout;
        logic [NUM_CH-1:0] pend;
        string             name;
    } exp_t;

    typedef struct {
        logic              en;
        logic              clr;
        logic              ld;
        logic [SEL_W-1:0]  sel;
        logic [CNT_W-1:0]  val;
        logic [NUM_CH-1:0] tick;
        logic [NUM_CH-1:0] cout;
        logic [NUM_CH-1:0] pend;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[20];

    prog_clock_divider #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .DEF_DIV(DEF_DIV),
        .SEL_W  (SEL_W)
    ) dut (
        .cin     (cin),
        .rst_n   (rst_n),
        .en      (en),
        .sync_clr(sync_clr),
        .div_ld  (div_ld),
        .div_sel (div_sel),
        .div_val (div_val),
        .ld_pend (ld_pend),
        .tick    (tick),
        .cout    (cout)
    );

    always #5 cin = ~cin;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [NUM_CH-1:0] act,
                         input logic [NUM_CH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Number of terminal events up to edge n for a tick train starting at
    // edge 'first' and repeating every 'period' edges.
    function automatic int ticks_by(input int n, input int first, input int period);
        return (n >= first) ? (n - first) / period + 1 : 0;
    endfunction

    function automatic bit tick_at(input int n, input int first, input int period);
        return (n >= first) && (((n - first) % period) == 0);
    endfunction

    // Drive one cycle of inputs, queue its expectation, then compare after the edge.
    task automatic cycle(input logic e, input logic c, input logic l,
                         input logic [SEL_W-1:0] s, input logic [CNT_W-1:0] v,
                         input logic [NUM_CH-1:0] et, input logic [NUM_CH-1:0] ec,
                         input logic [NUM_CH-1:0] ep, input string name);
        exp_t x;
        exp_t got;
        en = e; sync_clr = c; div_ld = l; div_sel = s; div_val = v;
        x.tick = et; x.cout = ec; x.pend = ep; x.name = name;
        sb_q.push_back(x);
        @(posedge cin);
        #1;
        got = sb_q.pop_front();
        check({got.name, " tick"}, tick, got.tick);
        check({got.name, " cout"}, cout, got.cout);
        check({got.name, " ld_pend"}, ld_pend, got.pend);
        div_ld = 1'b0;
        sync_clr = 1'b0;
    endtask

    // Assert reset between clock edges and check the outputs clear at once.
    // The next cycle() call then drives the first edge after release.
    task automatic apply_reset(input string name);
        #3 rst_n = 1'b0;
        en = 1'b0; sync_clr = 1'b0; div_ld = 1'b0;
        #1;
        check({name, " tick"}, tick, '0);
        check({name, " cout"}, cout, '0);
        check({name, " ld_pend"}, ld_pend, '0);
        repeat (2) @(posedge cin);
        #1 rst_n = 1'b1;
    endtask

    // Free-running channels at DEF_DIV with no loads.
    task automatic run_default(input int cycles, input string tag);
        logic [NUM_CH-1:0] et, ec;
        for (int n = 1; n <= cycles; n++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                et[k] = tick_at(n, DEF_P, DEF_P);
                ec[k] = ticks_by(n, DEF_P, DEF_P) % 2 == 1;
            end
            cycle(1'b1, 1'b0, 1'b0, '0, '0, et, ec, '0, $sformatf("%s n%0d", tag, n));
        end
    endtask

    initial begin
        apply_reset("reset0");

`ifdef CLKDIV_CASCADE_EN
        begin : cascade
            int first[NUM_CH];
            int period[NUM_CH];
            logic [NUM_CH-1:0] et, ec, ep;
            first[0] = 2;
            period[0] = 2;
            for (int k = 1; k < NUM_CH; k++) begin
                first[k]  = first[k-1] + 1 + (1 << k);
                period[k] = 1 << (k + 1);
            end
            ep = '0;
            for (int k = 0; k < NUM_CH; k++) begin
                ep[k] = 1'b1;
                cycle(1'b0, 1'b0, 1'b1, SEL_W'(k), 16'd1, '0, '0, ep,
                      $sformatf("casc load%0d", k));
            end
            cycle(1'b0, 1'b1, 1'b0, '0, '0, '0, '0, '0, "casc clr");
            for (int n = 1; n <= 64; n++) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    et[k] = tick_at(n, first[k], period[k]);
                    ec[k] = ticks_by(n, first[k], period[k]) % 2 == 1;
                end
                cycle(1'b1, 1'b0, 1'b0, '0, '0, et, ec, '0, $sformatf("casc n%0d", n));
            end
            for (int n = 0; n < 5; n++) begin
                cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, ec, '0, $sformatf("casc freeze%0d", n));
            end
        end
`else
        // Short hand-derived table: loads, an ignored out-of-range load,
        // overwrite while pending, sync_clr priority, divisors 3/0/1 and en=0.
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 3'd1, 16'd3,  4'b0000, 4'b0000, 4'b0010};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 3'd2, 16'd0,  4'b0000, 4'b0000, 4'b0110};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 3'd5, 16'd7,  4'b0000, 4'b0000, 4'b0110};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 3'd1, 16'd9,  4'b0000, 4'b0000, 4'b0110};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 3'd1, 16'd3,  4'b0000, 4'b0000, 4'b0110};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 3'd3, 16'd1,  4'b0000, 4'b0000, 4'b1000};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 3'd0, 16'd0,  4'b0100, 4'b0100, 4'b1000};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 3'd0, 16'd0,  4'b0100, 4'b0000, 4'b1000};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 3'd0, 16'd0,  4'b0100, 4'b0100, 4'b1000};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 3'd0, 16'd0,  4'b0110, 4'b0010, 4'b1000};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 3'd0, 16'd60, 4'b0000, 4'b0010, 4'b1001};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 3'd0, 16'd0,  4'b0100, 4'b0110, 4'b1001};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 3'd0, 16'd0,  4'b0100, 4'b0010, 4'b1001};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 3'd0, 16'd0,  4'b0100, 4'b0110, 4'b1001};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 3'd0, 16'd0,  4'b0110, 4'b0000, 4'b1001};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 3'd0, 16'd0,  4'b0000, 4'b0000, 4'b0000};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 3'd0, 16'd0,  4'b0100, 4'b0100, 4'b0000};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 3'd0, 16'd0,  4'b1100, 4'b1000, 4'b0000};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 3'd0, 16'd0,  4'b0100, 4'b1100, 4'b0000};
        tbl[19] = '{1'b1, 1'b0, 1'b0, 3'd0, 16'd0,  4'b1110, 4'b0010, 4'b0000};
        for (int i = 0; i < 20; i++) begin
            cycle(tbl[i].en, tbl[i].clr, tbl[i].ld, tbl[i].sel, tbl[i].val,
                  tbl[i].tick, tbl[i].cout, tbl[i].pend, $sformatf("tbl%0d", i));
        end

        // Default divisor: tick every 61 cycles, cout period 122.
        apply_reset("reset1");
        run_default(250, "dflt");

        // Mid-period load of 3 on ch1 at edge 20. It applies at ch1's
        // terminal on edge 61, and ticks then follow every 4 cycles.
        apply_reset("reset2");
        begin : mid_load
            logic [NUM_CH-1:0] et, ec, ep;
            for (int n = 1; n <= 100; n++) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    et[k] = tick_at(n, DEF_P, DEF_P);
                    ec[k] = ticks_by(n, DEF_P, DEF_P) % 2 == 1;
                end
                et[1] = tick_at(n, 61, 4);
                ec[1] = ticks_by(n, 61, 4) % 2 == 1;
                ep = '0;
                ep[1] = (n >= 20) && (n < 61);
                cycle(1'b1, 1'b0, n == 20, 3'd1, 16'd3, et, ec, ep,
                      $sformatf("ld1 n%0d", n));
            end
        end

        // Ch0 loads 5 at edge 30, then loads 2 in the same cycle as its
        // terminal on edge 61. Edge 61 applies 5, and edge 67 applies 2.
        // An out-of-range load (sel=5) arrives at edge 40. Ch1 loads 2 at
        // edge 95 and stays pending through the reset below.
        apply_reset("reset3");
        begin : term_load
            logic [NUM_CH-1:0] et, ec, ep;
            logic              l;
            logic [SEL_W-1:0]  s;
            logic [CNT_W-1:0]  v;
            int                k0;
            for (int n = 1; n <= 100; n++) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    et[k] = tick_at(n, DEF_P, DEF_P);
                    ec[k] = ticks_by(n, DEF_P, DEF_P) % 2 == 1;
                end
                k0 = (n >= 61 ? 1 : 0) + ticks_by(n, 67, 3);
                et[0] = (n == 61) || tick_at(n, 67, 3);
                ec[0] = (k0 % 2) == 1;
                ep = '0;
                ep[0] = (n >= 30) && (n < 67);
                ep[1] = (n >= 95);
                l = 1'b1; s = 3'd0; v = 16'd0;
                case (n)
                    30:      begin s = 3'd0; v = 16'd5; end
                    40:      begin s = 3'd5; v = 16'd1; end
                    61:      begin s = 3'd0; v = 16'd2; end
                    95:      begin s = 3'd1; v = 16'd2; end
                    default: l = 1'b0;
                endcase
                cycle(1'b1, 1'b0, l, s, v, et, ec, ep, $sformatf("tld n%0d", n));
            end
        end

        // Reset mid-period, with cout high and a load pending. Counting must
        // restart from 0 with DEF_DIV, and the pending ch1 load is lost.
        apply_reset("reset_mid");
        run_default(130, "post");
`endif

        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prog_clock_divider.md
PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 16, width of each channel counter and divisor.
REQ-003 The block SHALL have parameter DEF_DIV, default 60, reset terminal-count value of every channel.
REQ-004 The block SHALL have parameter SEL_W, default 2, width of div_sel (SEL_W >= ceil(log2(NUM_CH)), minimum 1).
REQ-005 Port cin, input, 1: the single clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port en, input, 1: global count enable.
REQ-008 Port sync_clr, input, 1: synchronous clear of all channels.
REQ-009 Port div_ld, input, 1: one-cycle divisor load strobe.
REQ-010 Port div_sel, input, SEL_W: channel targeted by div_ld.
REQ-011 Port div_val, input, CNT_W: new terminal-count value.
REQ-012 Port ld_pend, output, NUM_CH: per-channel flag, set while a loaded divisor awaits application.
REQ-013 Port tick, output, NUM_CH: per-channel one-cycle pulse at terminal count.
REQ-014 Port cout, output, NUM_CH: per-channel divided square wave.

Function
REQ-015 Each channel SHALL hold a count, an active divisor, a shadow divisor and a pending flag.
REQ-016 A channel event SHALL occur in every cin cycle in which en=1; an event at count==active SHALL set count to 0, and any other event SHALL increment count by 1.
REQ-017 tick[k] SHALL be registered and high for exactly the one cycle after the terminal event; cout[k] SHALL toggle on that same edge, giving a tick period of (active+1) events and a cout period of 2*(active+1) events.
REQ-018 An active divisor of 0 SHALL produce a tick on every event, with cout toggling every event.
REQ-019 With en=0, count and cout SHALL hold and tick SHALL be 0; loads SHALL still be accepted.
REQ-020 div_ld with div_sel<NUM_CH SHALL write shadow[div_sel] and set ld_pend[div_sel] on the next edge.
REQ-021 div_ld with div_sel>=NUM_CH SHALL be ignored.
REQ-022 A repeated load while pending SHALL overwrite the shadow, with ld_pend remaining 1.
REQ-023 A pending shadow SHALL be copied to active, and ld_pend SHALL clear, only on that channel's terminal event, so no truncated or stretched period occurs.
REQ-024 A load in the same cycle as that channel's terminal event SHALL NOT affect that terminal; the terminal SHALL transfer the pre-existing shadow if pending, and the new value SHALL remain pending for the next terminal.
REQ-025 sync_clr=1 SHALL set all counts to 0, cout to 0 and tick to 0, and SHALL copy every pending shadow to active and clear ld_pend; it SHALL take priority over events, and a load in the same cycle SHALL remain pending.

Reset
REQ-026 rst_n=0 SHALL immediately set count=0, active=shadow=DEF_DIV, ld_pend=0, tick=0 and cout=0 on all channels, regardless of cin.
REQ-027 After rst_n deasserts, channels SHALL resume counting from 0 on the first enabled edge; reset asserted mid-period SHALL discard the partial period and any pending load.

Configuration
REQ-028 With macro CLKDIV_CASCADE_EN defined, channel 0 events SHALL be en, and channel k>0 events SHALL be en AND tick[k-1], so that the channels form a cascaded prescaler chain.
REQ-029 Without CLKDIV_CASCADE_EN, every channel SHALL count cin directly per REQ-016, independently of the others.

Verification
REQ-030 Reset, en=1, no loads, non-cascade: tick[0] SHALL pulse every 61 cycles, cout[0] SHALL have a period of 122 cycles, and ld_pend SHALL be 0.
REQ-031 Load div_val=3 on ch1 mid-period: ld_pend[1] SHALL be 1 until ch1's next terminal, after which tick[1] SHALL pulse every 4 cycles with no short period.
REQ-032 Load div_val=0 on ch2, then sync_clr: ld_pend[2] SHALL clear, and tick[2] SHALL be high every cycle from the first enabled edge after the clear, with cout[2] toggling each cycle.
REQ-033 Load on ch0 coinciding with ch0's terminal event, and load div_sel=5 with NUM_CH=4: the ch0 value SHALL apply one terminal later, and the out-of-range load SHALL change no state.
REQ-034 CLKDIV_CASCADE_EN defined, all divisors 1: tick[1] SHALL pulse every 4 cycles and tick[3] every 16 cycles; en=0 SHALL freeze all cout values.
REQ-035 Assert rst_n low between cin edges mid-period: all outputs SHALL be 0 immediately, and counting SHALL restart from 0 with DEF_DIV.
